// File: rtl/bias_enable_sequencer.sv
// bias_enable_sequencer: power-up sequencer driving bg_enable of the bias generator.
// Ports: clk, rst_n (async active-low); en_req (sync level request);
// supply_ok, bias_fault (async, 2-flop synchronized); bg_enable, bias_ready,
// lockout, retry_cnt[2:0], state[2:0] (debug encoding), all registered.
module bias_enable_sequencer #(
    parameter int SUPPLY_DEB_CYC = 16,
    parameter int SETTLE_CYC     = 200,
    parameter int COOLDOWN_CYC   = 64,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_req,
    input  logic       supply_ok,
    input  logic       bias_fault,
    output logic       bg_enable,
    output logic       bias_ready,
    output logic       lockout,
    output logic [2:0] retry_cnt,
    output logic [2:0] state
);
    localparam logic [2:0] S_OFF      = 3'd0;
    localparam logic [2:0] S_SUP_WAIT = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_ON       = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;
    localparam logic [2:0] S_LOCKOUT  = 3'd5;
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(SUPPLY_DEB_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    logic [1:0]       sok_sync, flt_sync;
    logic             supply_ok_s, bias_fault_s, fault, retry_ok;
    logic [2:0]       state_nxt, retry_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    assign supply_ok_s  = sok_sync[1];
    assign bias_fault_s = flt_sync[1];
    assign fault        = bias_fault_s | ~supply_ok_s;
    assign retry_ok     = retry_cnt < 3'(MAX_RETRY);
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        if (state != S_OFF && !en_req)
            state_nxt = S_OFF;
        else
            case (state)
                S_OFF:      state_nxt = en_req ? S_SUP_WAIT : S_OFF;
                S_SUP_WAIT: state_nxt = (supply_ok_s && cnt == DEB_LAST) ? S_SETTLE : S_SUP_WAIT;
                S_SETTLE, S_ON: begin
                    // fault outranks settle expiry
                    if (fault) begin
                        state_nxt = retry_ok ? S_COOLDOWN : S_LOCKOUT;
                        retry_nxt = retry_cnt + {2'b0, retry_ok};
                    end else if (state == S_SETTLE && cnt == SETTLE_LAST)
                        state_nxt = S_ON;
                end
                S_COOLDOWN: state_nxt = (cnt == COOL_LAST) ? S_SUP_WAIT : S_COOLDOWN;
                default:    state_nxt = state;
            endcase
        if (state_nxt == S_OFF)
            retry_nxt = '0;
        // debounce restarts on any low supply sample; otherwise saturating count
        cnt_nxt = (state_nxt != state || (state == S_SUP_WAIT && !supply_ok_s)) ? '0 :
                  (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sok_sync   <= '0;
            flt_sync   <= '0;
            state      <= S_OFF;
            cnt        <= '0;
            retry_cnt  <= '0;
            bg_enable  <= 1'b0;
            bias_ready <= 1'b0;
            lockout    <= 1'b0;
        end else begin
            sok_sync   <= {sok_sync[0], supply_ok};
            flt_sync   <= {flt_sync[0], bias_fault};
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retry_cnt  <= retry_nxt;
            bg_enable  <= state_nxt == S_SETTLE || state_nxt == S_ON;
            bias_ready <= state_nxt == S_ON;
            lockout    <= state_nxt == S_LOCKOUT;
        end
    end
endmodule
